stall_fifo: RTL
===============

Name: stall_fifo

Overview:
- Elastic buffer placed directly downstream of the shiftbuffer pipeline stage.
- Captures every valid word the pipeline emits and hands it to a ready/valid consumer in first-word-fall-through order.
- Generates the `i_stall` back-pressure signal for the upstream shiftbuffer. Stall asserts early enough that every word still in flight in the pipeline can be absorbed.
- Words that arrive while full are dropped and flagged; they are never overwritten.

Parameters:
- p_width, 8: data word width in bits.
- p_depth, 16: storage entries. Legal range 2..1024; power of two not required.
- p_margin, 7: headroom reserved for in-flight words; set to the upstream p_stages. Must satisfy 0 < p_margin < p_depth.

Ports:
- i_clk, input, 1: clock. All state updates on the rising edge.
- i_rst, input, 1: reset, asynchronous and active-high.
- in, input, p_width: write data from upstream.
- in_valid, input, 1: write strobe; one word per cycle when high.
- o_stall, output, 1: back-pressure to upstream (drives its `i_stall`).
- out, output, p_width: head-of-queue data.
- out_valid, output, 1: head word present.
- i_ready, input, 1: consumer accepts the head word this cycle.
- o_count, output, clog2(p_depth+1): current occupancy.
- o_overflow, output, 1: sticky flag, set when a word is dropped.

Behaviour:
- Reset (async assert, sync release): rd_ptr=0, wr_ptr=0, count=0, out_valid=0, out=0, o_stall=0, o_overflow=0. Storage RAM contents are not reset.
- Reset asserted mid-operation discards all queued data immediately, without waiting for a clock edge.
- pop = out_valid & i_ready. Pop advances rd_ptr.
- push = in_valid & (count < p_depth | pop). Push writes `in` at wr_ptr and advances wr_ptr.
- Pointers wrap from p_depth-1 to 0 (explicit compare; not power-of-two masking).
- count next value:
  - count+1 on push only.
  - count-1 on pop only.
  - unchanged on both or neither.
- Full with simultaneous push and pop: both execute, count stays p_depth, no drop.
- Drop: in_valid & count==p_depth & !pop.
  - The word is discarded; pointers and count are unchanged.
  - o_overflow sets on the next edge and stays set until reset.
- Empty with push: out_valid rises the cycle after the push edge; out = written word. Write-to-read latency is 1 cycle; there is no combinational in-to-out path.
- Empty with no push: out_valid=0. i_ready is ignored; count never underflows.
- out_valid = (count != 0).
- out is the head entry. Implementation may use a registered head or RAM read-ahead, but out must be valid in the same cycle out_valid is high.
- out and out_valid hold stable while out_valid & !i_ready.
- o_stall = (count >= p_depth - p_margin), derived from registered count only (no combinational path from in_valid or i_ready).
  - Deasserts the cycle after count drops below the threshold.
- o_count = count (registered).
- Push and pop are independent of o_stall. The block keeps accepting in_valid while stalling, because the upstream pipeline drains in-flight words.

Test Plan (p_width=8, p_depth=16, p_margin=7):
- Reset, then push 1,2,3 on consecutive cycles with i_ready=0 -> out_valid rises one cycle after the first push; out=1; o_count=3; o_stall=0.
- Push 9 words with i_ready=0 -> o_stall=1 on the cycle after the 9th push edge (count=9); count=8 gives o_stall=0.
- Fill to 16, then push 0xAA with i_ready=0 -> word dropped; o_count stays 16; o_overflow=1 and remains 1. Drain all 16 -> output sequence matches push order with no 0xAA.
- Full, push 0x55 with i_ready=1 in the same cycle -> head popped, 0x55 enqueued, o_count=16, o_overflow stays 0; 0x55 emerges last.
- Push 20 words while popping every cycle -> pointers wrap past 15; the output sequence is exactly 20 words in order; o_count stays at 1.
- Assert i_rst asynchronously mid-clock with count=5 -> out_valid, o_count, o_stall and o_overflow go to 0 before the next edge. After release, the first push reappears with latency 1.

Source files
------------

// File: rtl/stall_fifo.sv
// Elastic FWFT buffer behind the shiftbuffer pipeline; raises o_stall while p_margin slots of headroom remain.
// Write-to-read latency 1 cycle; words arriving while full (and not popping) are dropped and flag o_overflow.
module stall_fifo #(
    parameter int p_width  = 8,
    parameter int p_depth  = 16,
    parameter int p_margin = 7
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [p_width-1:0]           in,
    input  logic                         in_valid,
    output logic                         o_stall,
    output logic [p_width-1:0]           out,
    output logic                         out_valid,
    input  logic                         i_ready,
    output logic [$clog2(p_depth+1)-1:0] o_count,
    output logic                         o_overflow
);

    localparam int CW = $clog2(p_depth + 1);
    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(p_depth);
    localparam logic [CW-1:0] STALL_AT = CW'(p_depth - p_margin);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [PW-1:0] LAST_PTR = PW'(p_depth - 1);

    logic [p_width-1:0] mem [p_depth];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_next;
    logic [PW-1:0] wr_next;
    logic [CW-1:0] count;

    logic pop;
    logic push;
    logic drop;
    logic empty_after_pop;

    assign pop  = out_valid & i_ready;
    assign push = in_valid & ((count < DEPTH_C) | pop);
    assign drop = in_valid & (count == DEPTH_C) & ~pop;

    // Queue is empty once this cycle's pop (if any) retires; a push then goes straight to the head.
    assign empty_after_pop = pop ? (count == ONE_C) : (count == '0);

    always_comb begin
        rd_next = rd_ptr;
        if (pop) begin
            rd_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
        end
    end

    always_comb begin
        wr_next = wr_ptr;
        if (push) begin
            wr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= in;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            out        <= '0;
            out_valid  <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_next;

            if (push && !pop) begin
                count <= count + ONE_C;
            end else if (pop && !push) begin
                count <= count - ONE_C;
            end

            // Head register: bypass into an empty queue, otherwise read ahead only from written slots.
            if (push && empty_after_pop) begin
                out <= in;
            end else if (pop && (count > ONE_C)) begin
                out <= mem[rd_next];
            end

            out_valid <= ~empty_after_pop | push;

            if (drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    assign o_count = count;
    assign o_stall = (count >= STALL_AT);

endmodule
